bomb_put_arbiter: RTL and testbench

Arbitrates player bomb-placement requests before they reach the bomb tile engine. It converts raw button levels into single-cycle `p1_put`/`p2_put` pulses. A request is granted only when the player is under capacity, the target tile is free and not exploding, and the tile does not conflict with the other player. Per-player fuse-slot timers track live bombs so capacity is enforced locally.

---
 rtl/bomb_pkg.sv | 38 +++
 rtl/bomb_put_arbiter_if.sv | 31 +++
 rtl/bomb_slot_tracker.sv | 53 +++++
 rtl/bomb_put_arbiter.sv | 153 +++++++++++++++
 tb/tb_bomb_put_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bomb_pkg.sv
// bomb_pkg
//   Shared constants and types for the bomb subsystem: tile states, player
//   identifiers, fuse/explosion timing and small helper functions used by
//   the placement arbiter.
package bomb_pkg;

  typedef enum logic [2:0] {
    EMPTY      = 3'd0,
    BOMB_UN    = 3'd1,
    EXP_CENTER = 3'd2,
    EXP_HORIZ  = 3'd3,
    EXP_VERT   = 3'd4
  } tile_state_e;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_e;

  localparam int FUSE         = 60;
  localparam int EXP_HOLD     = 30;
  // A slot stays busy for the fuse plus the cycle the tile engine needs to
  // turn the bomb into an explosion.
  localparam int LIFETIME_DEF = FUSE + 1;
  localparam int NSLOT_DEF    = 4;

  // Capacity of 0 behaves as 1; anything above the slot count saturates.
  function automatic logic [2:0] eff_cap(input logic [2:0] cap,
                                         input logic [2:0] max_slots);
    if (cap == 3'd0)
      return 3'd1;
    else if (cap > max_slots)
      return max_slots;
    else
      return cap;
  endfunction

endpackage

// File: rtl/bomb_put_arbiter_if.sv
// bomb_put_arbiter_if
//   Player-side and tile-engine-side signals of the bomb placement arbiter.
//   master : drives buttons, coordinates, capacities and tile maps
//   slave  : the arbiter; returns put/deny pulses, live counts and conflict
interface bomb_put_arbiter_if;
  logic         p1_req;
  logic         p2_req;
  logic [7:0]   p1_cor;
  logic [7:0]   p2_cor;
  logic [2:0]   p1_cap;
  logic [2:0]   p2_cap;
  logic [255:0] bomb_un_grid;
  logic [255:0] explode;
  logic         p1_put;
  logic         p2_put;
  logic         p1_deny;
  logic         p2_deny;
  logic [2:0]   p1_active;
  logic [2:0]   p2_active;
  logic         conflict;

  modport master (
    output p1_req, p2_req, p1_cor, p2_cor, p1_cap, p2_cap, bomb_un_grid, explode,
    input  p1_put, p2_put, p1_deny, p2_deny, p1_active, p2_active, conflict
  );

  modport slave (
    input  p1_req, p2_req, p1_cor, p2_cor, p1_cap, p2_cap, bomb_un_grid, explode,
    output p1_put, p2_put, p1_deny, p2_deny, p1_active, p2_active, conflict
  );
endinterface

// File: rtl/bomb_slot_tracker.sv
// bomb_slot_tracker
//   Per-player fuse slots. Each slot is a down-counter; a slot is busy while
//   its counter is non-zero. An allocate request loads LIFETIME into the
//   lowest free slot. The live count is the popcount of busy slots.
//   clk, reset : clock, async active-high reset
//   i_alloc    : claim a slot this cycle
//   o_active   : number of busy slots (from registered state)
module bomb_slot_tracker
  import bomb_pkg::*;
#(
  parameter int LIFETIME = LIFETIME_DEF,
  parameter int NSLOT    = NSLOT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_alloc,
  output logic [2:0] o_active
);

  localparam int CW = $clog2(LIFETIME + 1);

  logic [NSLOT-1:0][CW-1:0] r_cnt;
  logic [NSLOT-1:0]         w_busy;
  logic [NSLOT-1:0]         w_pick;
  logic [2:0]               w_count;

  always_comb begin
    w_count = 3'd0;
    for (int i = 0; i < NSLOT; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
      w_count   = w_count + {2'b00, w_busy[i]};
    end
  end

  // Lowest clear bit of w_busy; a slot releasing this cycle still reads busy,
  // so it cannot be handed out again until the following cycle.
  assign w_pick   = ~w_busy & (w_busy + 1'b1);
  assign o_active = w_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (i_alloc && w_pick[i])
          r_cnt[i] <= CW'(LIFETIME);
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bomb_put_arbiter.sv
// bomb_put_arbiter
//   Turns raw placement buttons into single-cycle put/deny pulses. An event is
//   granted when the player has a free slot under its capacity, the tile is
//   neither holding a bomb nor exploding, and it is not the tile granted in
//   the previous cycle (map-update lag). Same-tile collisions between players
//   are settled by a round-robin bit.
//   clk, reset : clock, async active-high reset
//   bus        : bomb_put_arbiter_if.slave (requests, maps, pulses, counts)
//   Optional macro BOMB_ARB_COOLDOWN_EN: per-player lockout of COOLDOWN
//   cycles counted from each put.
module bomb_put_arbiter
  import bomb_pkg::*;
#(
  parameter int LIFETIME  = LIFETIME_DEF,
  parameter int MAX_SLOTS = NSLOT_DEF
`ifdef BOMB_ARB_COOLDOWN_EN
  ,
  parameter int COOLDOWN  = 8
`endif
) (
  input  logic                clk,
  input  logic                reset,
  bomb_put_arbiter_if.slave   bus
);

  logic       r_p1_s1, r_p1_s2, r_p2_s1, r_p2_s2;
  logic       r_p1_put, r_p2_put, r_p1_deny, r_p2_deny, r_conflict;
  player_e    r_rr;
  logic       r_p1_lock_vld, r_p2_lock_vld;
  logic [7:0] r_p1_lock_cor, r_p2_lock_cor;

  logic       w_p1_evt, w_p2_evt;
  logic       w_p1_ok, w_p2_ok;
  logic       w_p1_gnt, w_p2_gnt;
  logic       w_conf;
  logic       w_p1_cd_ok, w_p2_cd_ok;
  logic [2:0] w_p1_active, w_p2_active;
  logic [2:0] w_p1_cap, w_p2_cap;

  assign w_p1_evt = r_p1_s1 & ~r_p1_s2;
  assign w_p2_evt = r_p2_s1 & ~r_p2_s2;

  assign w_p1_cap = eff_cap(bus.p1_cap, 3'(MAX_SLOTS));
  assign w_p2_cap = eff_cap(bus.p2_cap, 3'(MAX_SLOTS));

  assign w_p1_ok = w_p1_evt && (w_p1_active < w_p1_cap)
                   && !bus.bomb_un_grid[bus.p1_cor] && !bus.explode[bus.p1_cor]
                   && !(r_p1_lock_vld && (bus.p1_cor == r_p1_lock_cor))
                   && w_p1_cd_ok;
  assign w_p2_ok = w_p2_evt && (w_p2_active < w_p2_cap)
                   && !bus.bomb_un_grid[bus.p2_cor] && !bus.explode[bus.p2_cor]
                   && !(r_p2_lock_vld && (bus.p2_cor == r_p2_lock_cor))
                   && w_p2_cd_ok;

  // Collision only when both would otherwise be granted; r_rr names the winner.
  assign w_conf   = w_p1_ok && w_p2_ok && (bus.p1_cor == bus.p2_cor);
  assign w_p1_gnt = w_p1_ok && !(w_conf && (r_rr == P2));
  assign w_p2_gnt = w_p2_ok && !(w_conf && (r_rr == P1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_s1       <= 1'b0;
      r_p1_s2       <= 1'b0;
      r_p2_s1       <= 1'b0;
      r_p2_s2       <= 1'b0;
      r_p1_put      <= 1'b0;
      r_p2_put      <= 1'b0;
      r_p1_deny     <= 1'b0;
      r_p2_deny     <= 1'b0;
      r_conflict    <= 1'b0;
      r_rr          <= P1;
      r_p1_lock_vld <= 1'b0;
      r_p2_lock_vld <= 1'b0;
      r_p1_lock_cor <= 8'h00;
      r_p2_lock_cor <= 8'h00;
    end else begin
      r_p1_s1       <= bus.p1_req;
      r_p1_s2       <= r_p1_s1;
      r_p2_s1       <= bus.p2_req;
      r_p2_s2       <= r_p2_s1;
      r_p1_put      <= w_p1_gnt;
      r_p2_put      <= w_p2_gnt;
      r_p1_deny     <= w_p1_evt && !w_p1_gnt;
      r_p2_deny     <= w_p2_evt && !w_p2_gnt;
      r_conflict    <= w_conf;
      if (w_conf)
        r_rr <= (r_rr == P1) ? P2 : P1;
      r_p1_lock_vld <= w_p1_gnt;
      r_p2_lock_vld <= w_p2_gnt;
      if (w_p1_gnt)
        r_p1_lock_cor <= bus.p1_cor;
      if (w_p2_gnt)
        r_p2_lock_cor <= bus.p2_cor;
    end
  end

`ifdef BOMB_ARB_COOLDOWN_EN
  localparam int CDW = $clog2(COOLDOWN + 1);

  logic [CDW-1:0] r_p1_cd, r_p2_cd;

  assign w_p1_cd_ok = (r_p1_cd == '0);
  assign w_p2_cd_ok = (r_p2_cd == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_cd <= '0;
      r_p2_cd <= '0;
    end else begin
      if (w_p1_gnt)
        r_p1_cd <= CDW'(COOLDOWN);
      else if (r_p1_cd != '0)
        r_p1_cd <= r_p1_cd - 1'b1;
      if (w_p2_gnt)
        r_p2_cd <= CDW'(COOLDOWN);
      else if (r_p2_cd != '0)
        r_p2_cd <= r_p2_cd - 1'b1;
    end
  end
`else
  assign w_p1_cd_ok = 1'b1;
  assign w_p2_cd_ok = 1'b1;
`endif

  bomb_slot_tracker #(
    .LIFETIME (LIFETIME),
    .NSLOT    (MAX_SLOTS)
  ) u_p1_slots (
    .clk      (clk),
    .reset    (reset),
    .i_alloc  (w_p1_gnt),
    .o_active (w_p1_active)
  );

  bomb_slot_tracker #(
    .LIFETIME (LIFETIME),
    .NSLOT    (MAX_SLOTS)
  ) u_p2_slots (
    .clk      (clk),
    .reset    (reset),
    .i_alloc  (w_p2_gnt),
    .o_active (w_p2_active)
  );

  assign bus.p1_put    = r_p1_put;
  assign bus.p2_put    = r_p2_put;
  assign bus.p1_deny   = r_p1_deny;
  assign bus.p2_deny   = r_p2_deny;
  assign bus.conflict  = r_conflict;
  assign bus.p1_active = w_p1_active;
  assign bus.p2_active = w_p2_active;

endmodule

// File: tb/tb_bomb_put_arbiter.sv
// tb_bomb_put_arbiter
//   Directed-vector bench for bomb_put_arbiter. Inputs change 1 time unit
//   after each rising edge; outputs are sampled at the same point.
//   Build with BOMB_ARB_COOLDOWN_EN to exercise the cooldown variant.
module tb_bomb_put_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bomb_put_arbiter_if bus();

  bomb_put_arbiter #(
    .LIFETIME  (61),
    .MAX_SLOTS (4)
`ifdef BOMB_ARB_COOLDOWN_EN
    ,
    .COOLDOWN  (8)
`endif
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, bus.p1_put, bus.p2_put, bus.p1_deny, bus.p2_deny,
            bus.conflict, bus.p1_active, bus.p2_active};
  endfunction

  task automatic idle();
    bus.p1_req       = 1'b0;
    bus.p2_req       = 1'b0;
    bus.p1_cor       = 8'h00;
    bus.p2_cor       = 8'h00;
    bus.p1_cap       = 3'd4;
    bus.p2_cap       = 3'd4;
    bus.bomb_un_grid = '0;
    bus.explode      = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  // Raise the selected buttons; returns in the cycle the result is visible.
  task automatic press(input logic a, input logic b);
    bus.p1_req = a;
    bus.p2_req = b;
    step(2);
  endtask

  task automatic rel();
    bus.p1_req = 1'b0;
    bus.p2_req = 1'b0;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_put;
    int n_deny;

    // reset state
    idle();
    step(2);
    chk("reset_outs", outs(), 32'd0);
    reset = 1'b0;
    step(1);
    chk("idle_outs", outs(), 32'd0);

    // single put, capacity 1, expiry boundary
    bus.p1_cap = 3'd1;
    bus.p1_cor = 8'h22;
    bus.p1_req = 1'b1;
    step(1);
    chk("lat_n1_put", bus.p1_put, 1'b0);
    step(1);
    chk("single_put", bus.p1_put, 1'b1);
    chk("single_active", bus.p1_active, 3'd1);
    bus.p1_req = 1'b0;
    step(1);
    chk("put_one_cycle", bus.p1_put, 1'b0);
    step(8);
    bus.p1_req = 1'b1;
    step(2);
    chk("cap1_deny", {bus.p1_put, bus.p1_deny}, 2'b01);
    chk("cap1_active", bus.p1_active, 3'd1);
    bus.p1_req = 1'b0;
    step(48);
    chk("active_p59", bus.p1_active, 3'd1);
    bus.p1_req = 1'b1;
    step(1);
    chk("active_p60", bus.p1_active, 3'd1);
    step(1);
    chk("release_same_cycle_deny", {bus.p1_put, bus.p1_deny}, 2'b01);
    chk("active_p61", bus.p1_active, 3'd0);
    bus.p1_req = 1'b0;
    step(1);
    press(1'b1, 1'b0);
    chk("regrant_put", bus.p1_put, 1'b1);
    chk("regrant_active", bus.p1_active, 3'd1);
    rel();

    // same-tile conflict, round robin
    do_reset();
    bus.p1_cor = 8'h35;
    bus.p2_cor = 8'h35;
    press(1'b1, 1'b1);
    chk("conf1_pulses", {bus.p1_put, bus.p2_put, bus.p1_deny, bus.p2_deny, bus.conflict}, 5'b10011);
    rel();
    chk("conf_one_cycle", bus.conflict, 1'b0);
    bus.p1_cor = 8'h36;
    bus.p2_cor = 8'h36;
    press(1'b1, 1'b1);
    chk("conf2_pulses", {bus.p1_put, bus.p2_put, bus.p1_deny, bus.p2_deny, bus.conflict}, 5'b01101);
    rel();
    bus.p1_cor = 8'h40;
    bus.p2_cor = 8'h41;
    press(1'b1, 1'b1);
    chk("diff_tiles", {bus.p1_put, bus.p2_put, bus.p1_deny, bus.p2_deny, bus.conflict}, 5'b11000);
    chk("diff_active", {bus.p1_active, bus.p2_active}, 6'o22);
    rel();

    // occupied / exploding tile
    do_reset();
    bus.p2_cor = 8'h10;
    bus.bomb_un_grid[8'h10] = 1'b1;
    press(1'b0, 1'b1);
    chk("occupied_deny", {bus.p2_put, bus.p2_deny}, 2'b01);
    chk("occupied_active", bus.p2_active, 3'd0);
    rel();
    bus.bomb_un_grid = '0;
    bus.explode[8'h10] = 1'b1;
    press(1'b0, 1'b1);
    chk("explode_deny", {bus.p2_put, bus.p2_deny}, 2'b01);
    chk("explode_active", bus.p2_active, 3'd0);
    rel();
    bus.explode = '0;
    bus.bomb_un_grid[8'h11] = 1'b1;
    press(1'b0, 1'b1);
    chk("neighbour_put", {bus.p2_put, bus.p2_deny}, 2'b10);
    chk("neighbour_active", bus.p2_active, 3'd1);
    rel();

    // capacity saturation
    do_reset();
    bus.p1_cap = 3'd7;
    for (int i = 0; i < 5; i++) begin
      bus.p1_cor = 8'h50 + 8'(i);
      press(1'b1, 1'b0);
      chk($sformatf("cap7_press%0d", i), {bus.p1_put, bus.p1_deny}, (i < 4) ? 2'b10 : 2'b01);
      rel();
    end
    chk("cap7_active", bus.p1_active, 3'd4);
    do_reset();
    bus.p1_cap = 3'd0;
    for (int i = 0; i < 2; i++) begin
      bus.p1_cor = 8'h58 + 8'(i);
      press(1'b1, 1'b0);
      chk($sformatf("cap0_press%0d", i), {bus.p1_put, bus.p1_deny}, (i < 1) ? 2'b10 : 2'b01);
      rel();
    end
    chk("cap0_active", bus.p1_active, 3'd1);

    // button held for 100 cycles
    do_reset();
    bus.p1_cor = 8'h60;
    bus.p1_req = 1'b1;
    n_put  = 0;
    n_deny = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      n_put  += int'(bus.p1_put);
      n_deny += int'(bus.p1_deny);
    end
    chk("held_puts", n_put, 1);
    chk("held_denies", n_deny, 0);
    rel();

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.p2_cor = 8'h70 + 8'(i);
      press(1'b0, 1'b1);
      rel();
    end
    chk("pre_reset_active", bus.p2_active, 3'd3);
    bus.p2_cor = 8'h73;
    bus.p2_req = 1'b1;
    step(1);
    reset      = 1'b1;
    bus.p2_req = 1'b0;
    #1;
    chk("reset_async_outs", outs(), 32'd0);
    step(1);
    chk("reset_edge_outs", outs(), 32'd0);
    reset = 1'b0;
    step(3);
    chk("post_reset_outs", outs(), 32'd0);

    // cooldown: second press 4 cycles after the first, third 9 after the put
    do_reset();
    bus.p1_cor = 8'h80;
    press(1'b1, 1'b0);
    chk("cd_first_put", bus.p1_put, 1'b1);
    rel();
    step(1);
    bus.p1_cor = 8'h81;
    press(1'b1, 1'b0);
`ifdef BOMB_ARB_COOLDOWN_EN
    chk("cd_second", {bus.p1_put, bus.p1_deny}, 2'b01);
`else
    chk("cd_second", {bus.p1_put, bus.p1_deny}, 2'b10);
`endif
    rel();
    step(4);
    bus.p1_cor = 8'h82;
    press(1'b1, 1'b0);
    chk("cd_third_put", {bus.p1_put, bus.p1_deny}, 2'b10);
    rel();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
